ldpc_layer_scheduler: RTL and testbench

LDPC_LAYER_SCHEDULER -- requirements
Module: ldpc_layer_scheduler

---
 rtl/ldpc_pkg.sv | 21 ++
 rtl/ldpc_addr_counter.sv | 42 ++++
 rtl/ldpc_layer_scheduler.sv | 138 +++++++++++++
 tb/tb_ldpc_layer_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared types and constants for the LDPC layer scheduler: FSM state
// encoding, iteration-counter width and a minimum-one width helper.
package ldpc_pkg;

    localparam int ITER_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        GAP,
        CHECK,
        DONE
    } state_t;

    // A counter over n values needs at least one bit, even when n is 1.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ldpc_addr_counter.sv
// Column/layer counter for the LDPC layer scheduler. The column wraps every
// COLS_PER_LAYER steps; the layer saturates at its last value.
module ldpc_addr_counter
    import ldpc_pkg::*;
#(
    parameter int NUM_LAYERS     = 4,
    parameter int COLS_PER_LAYER = 8,
    parameter int LAYER_W        = width_of(NUM_LAYERS),
    parameter int COL_W          = width_of(COLS_PER_LAYER)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    output logic [COL_W-1:0]   col,
    output logic [LAYER_W-1:0] layer,
    output logic               col_wrap,
    output logic               layer_wrap
);

    assign col_wrap   = (col == COL_W'(COLS_PER_LAYER - 1));
    assign layer_wrap = (layer == LAYER_W'(NUM_LAYERS - 1));

    // On the last layer the layer index holds so the scheduler can decide
    // between a new iteration and completion before anything is rewound.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            col   <= '0;
            layer <= '0;
        end else if (enable) begin
            if (col_wrap) begin
                col <= '0;
                if (!layer_wrap) begin
                    layer <= layer + LAYER_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/ldpc_layer_scheduler.sv
// Layered LDPC decode address scheduler: walks layer/column addresses per
// iteration. Optional early termination on syndrome_ok: LDPC_EARLY_TERM_EN.
module ldpc_layer_scheduler
    import ldpc_pkg::*;
#(
    parameter int  ADDR_WIDTH     = 8,
    parameter int  NUM_LAYERS     = 4,
    parameter int  COLS_PER_LAYER = 8,
    localparam int LAYER_W        = width_of(NUM_LAYERS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ITER_W-1:0]     max_iter,
    input  logic                  ready,
    input  logic                  syndrome_ok,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_valid,
    output logic [LAYER_W-1:0]    layer,
    output logic [ITER_W-1:0]     iter,
    output logic                  layer_last,
    output logic                  busy,
    output logic                  done
);

    localparam int COL_W = width_of(COLS_PER_LAYER);

    state_t              state;
    state_t              state_next;
    logic [ITER_W-1:0]   limit;
    logic [COL_W-1:0]    col;
    logic                col_wrap;
    logic                layer_wrap;
    logic                cnt_enable;
    logic                cnt_clear;
    logic                last_iter;
    logic                check_exit;

    ldpc_addr_counter #(
        .NUM_LAYERS     (NUM_LAYERS),
        .COLS_PER_LAYER (COLS_PER_LAYER),
        .LAYER_W        (LAYER_W),
        .COL_W          (COL_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .clear      (cnt_clear),
        .enable     (cnt_enable),
        .col        (col),
        .layer      (layer),
        .col_wrap   (col_wrap),
        .layer_wrap (layer_wrap)
    );

    assign addr = ADDR_WIDTH'(layer) * ADDR_WIDTH'(COLS_PER_LAYER) + ADDR_WIDTH'(col);

    assign last_iter = ((iter + ITER_W'(1)) == limit);

`ifdef LDPC_EARLY_TERM_EN
    assign check_exit = last_iter || syndrome_ok;
`else
    wire unused_syndrome_ok = syndrome_ok;
    assign check_exit = last_iter;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero iteration limit is promoted to one so a decode always runs once.
    always_ff @(posedge clk) begin
        if (reset) begin
            iter  <= '0;
            limit <= ITER_W'(1);
        end else begin
            if (state == IDLE && start) begin
                limit <= (max_iter == '0) ? ITER_W'(1) : max_iter;
            end
            if (state == PREP) begin
                iter <= '0;
            end else if (state == CHECK && !check_exit) begin
                iter <= iter + ITER_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_enable = 1'b0;
        cnt_clear  = 1'b0;
        addr_valid = 1'b0;
        layer_last = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = PREP;
                end
            end
            PREP: begin
                cnt_clear  = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (ready) begin
                    addr_valid = 1'b1;
                    cnt_enable = 1'b1;
                    layer_last = col_wrap;
                    if (col_wrap) begin
                        state_next = layer_wrap ? CHECK : GAP;
                    end
                end
            end
            GAP: begin
                state_next = RUN;
            end
            CHECK: begin
                // Rewinding here is harmless on exit and required on loop-back.
                cnt_clear  = 1'b1;
                state_next = check_exit ? DONE : RUN;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ldpc_layer_scheduler.sv
// Directed, table-driven bench for ldpc_layer_scheduler with 2 layers of
// 4 columns; early-termination expectations follow LDPC_EARLY_TERM_EN.
module tb_ldpc_layer_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] max_iter = 4'd0;
    logic       ready = 1'b1;
    logic       syndrome_ok = 1'b0;
    logic [7:0] addr;
    logic       addr_valid;
    logic [0:0] layer;
    logic [3:0] iter;
    logic       layer_last;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic       ready;
        logic [3:0] max_iter;
        int         av;
        int         addr;
        int         layer;
        int         iter;
        int         ll;
        int         busy;
        int         done;
        int         care;
    } vec_t;

    vec_t tbl[24];

    int done_cycle;
    int done_count;
    int av_count;
    int addr_sum;
    int iter_at_done;
    int busy_after;

    ldpc_layer_scheduler #(
        .ADDR_WIDTH     (8),
        .NUM_LAYERS     (2),
        .COLS_PER_LAYER (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .max_iter    (max_iter),
        .ready       (ready),
        .syndrome_ok (syndrome_ok),
        .addr        (addr),
        .addr_valid  (addr_valid),
        .layer       (layer),
        .iter        (iter),
        .layer_last  (layer_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic s, input int av, input int a, input int l,
                                input int it, input int ll, input int b, input int d,
                                input int care);
        vec_t v;
        v.start = s; v.ready = 1'b1; v.max_iter = 4'd2;
        v.av = av; v.addr = a; v.layer = l; v.iter = it;
        v.ll = ll; v.busy = b; v.done = d; v.care = care;
        return v;
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 unit later.
    task automatic apply_stimulus(input logic s, input logic r, input logic y, input logic [3:0] m);
        @(negedge clk);
        start = s;
        ready = r;
        syndrome_ok = y;
        max_iter = m;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one decode started at cycle 0 and collects summary observations.
    task automatic run_decode(input logic [3:0] m, input logic syn, input int lo_first,
                              input int lo_last, input int hold_addr, input logic [63:0] smask);
        done_cycle = -1; done_count = 0; av_count = 0; addr_sum = 0;
        iter_at_done = -1; busy_after = 0;
        for (int c = 0; c < 60; c++) begin
            apply_stimulus((c == 0) || smask[c], !(c >= lo_first && c <= lo_last), syn, m);
            if (c >= lo_first && c <= lo_last) begin
                check_output("hold_addr", int'(addr), hold_addr);
                check_output("hold_valid", int'(addr_valid), 0);
            end
            if (addr_valid) begin
                av_count++;
                addr_sum += int'(addr);
            end
            if (done) begin
                done_count++;
                if (done_cycle < 0) begin
                    done_cycle = c;
                    iter_at_done = int'(iter);
                end
            end else if (done_cycle >= 0 && busy) begin
                busy_after = 1;
            end
        end
    endtask

    initial begin
        tbl[0]  = mk(1'b1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[1]  = mk(1'b0, 0, 0, 0, 0, 0, 1, 0, 1);
        tbl[2]  = mk(1'b0, 1, 0, 0, 0, 0, 1, 0, 1);
        tbl[3]  = mk(1'b0, 1, 1, 0, 0, 0, 1, 0, 1);
        tbl[4]  = mk(1'b0, 1, 2, 0, 0, 0, 1, 0, 1);
        tbl[5]  = mk(1'b0, 1, 3, 0, 0, 1, 1, 0, 1);
        tbl[6]  = mk(1'b0, 0, 4, 1, 0, 0, 1, 0, 1);
        tbl[7]  = mk(1'b0, 1, 4, 1, 0, 0, 1, 0, 1);
        tbl[8]  = mk(1'b0, 1, 5, 1, 0, 0, 1, 0, 1);
        tbl[9]  = mk(1'b0, 1, 6, 1, 0, 0, 1, 0, 1);
        tbl[10] = mk(1'b0, 1, 7, 1, 0, 1, 1, 0, 1);
        tbl[11] = mk(1'b0, 0, 4, 1, 0, 0, 1, 0, 1);
        tbl[12] = mk(1'b0, 1, 0, 0, 1, 0, 1, 0, 1);
        tbl[13] = mk(1'b0, 1, 1, 0, 1, 0, 1, 0, 1);
        tbl[14] = mk(1'b0, 1, 2, 0, 1, 0, 1, 0, 1);
        tbl[15] = mk(1'b0, 1, 3, 0, 1, 1, 1, 0, 1);
        tbl[16] = mk(1'b0, 0, 4, 1, 1, 0, 1, 0, 1);
        tbl[17] = mk(1'b0, 1, 4, 1, 1, 0, 1, 0, 1);
        tbl[18] = mk(1'b0, 1, 5, 1, 1, 0, 1, 0, 1);
        tbl[19] = mk(1'b0, 1, 6, 1, 1, 0, 1, 0, 1);
        tbl[20] = mk(1'b0, 1, 7, 1, 1, 1, 1, 0, 1);
        tbl[21] = mk(1'b0, 0, 4, 1, 1, 0, 1, 0, 1);
        tbl[22] = mk(1'b0, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[23] = mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Nominal two-iteration decode, cycle by cycle.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            apply_stimulus(tbl[i].start, tbl[i].ready, 1'b0, tbl[i].max_iter);
            check_output($sformatf("c%0d_valid", i), int'(addr_valid), tbl[i].av);
            check_output($sformatf("c%0d_last", i), int'(layer_last), tbl[i].ll);
            check_output($sformatf("c%0d_busy", i), int'(busy), tbl[i].busy);
            check_output($sformatf("c%0d_done", i), int'(done), tbl[i].done);
            if (tbl[i].care != 0) begin
                check_output($sformatf("c%0d_addr", i), int'(addr), tbl[i].addr);
                check_output($sformatf("c%0d_layer", i), int'(layer), tbl[i].layer);
                check_output($sformatf("c%0d_iter", i), int'(iter), tbl[i].iter);
            end
        end

        // Back-pressure: ready low for three cycles while addr 5 is presented.
        do_reset();
        run_decode(4'd2, 1'b0, 8, 10, 5, 64'd0);
        check_output("stall_done_cycle", done_cycle, 25);
        check_output("stall_done_count", done_count, 1);
        check_output("stall_av_count", av_count, 16);
        check_output("stall_addr_sum", addr_sum, 56);

        // Reset mid-decode together with a start that must be discarded.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            apply_stimulus(c == 0 || c == 8, 1'b1, 1'b0, 4'd2);
            if (c == 8) reset = 1'b1;
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd2);
        reset = 1'b0;
        check_output("rst_valid", int'(addr_valid), 0);
        check_output("rst_addr", int'(addr), 0);
        check_output("rst_layer", int'(layer), 0);
        check_output("rst_iter", int'(iter), 0);
        check_output("rst_last", int'(layer_last), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd2);
        check_output("rst_start_dropped", int'(busy), 0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd2);
        check_output("restart_prep_busy", int'(busy), 1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd2);
        check_output("restart_valid", int'(addr_valid), 1);
        check_output("restart_addr", int'(addr), 0);
        check_output("restart_iter", int'(iter), 0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd2);
        check_output("restart_addr1", int'(addr), 1);

        // Zero iteration limit behaves as one iteration.
        do_reset();
        run_decode(4'd0, 1'b0, -1, -1, 0, 64'd0);
        check_output("zero_done_cycle", done_cycle, 12);
        check_output("zero_av_count", av_count, 8);
        check_output("zero_addr_sum", addr_sum, 28);
        check_output("zero_iter", iter_at_done, 0);

        // Syndrome satisfied from the first CHECK onward.
        do_reset();
        run_decode(4'd5, 1'b1, -1, -1, 0, 64'd0);
`ifdef LDPC_EARLY_TERM_EN
        check_output("early_done_cycle", done_cycle, 12);
        check_output("early_iter", iter_at_done, 0);
        check_output("early_av_count", av_count, 8);
`else
        check_output("full_done_cycle", done_cycle, 52);
        check_output("full_iter", iter_at_done, 4);
        check_output("full_av_count", av_count, 40);
        check_output("full_addr_sum", addr_sum, 140);
`endif

        // Stray starts while busy and in the DONE cycle.
        do_reset();
        run_decode(4'd2, 1'b0, -1, -1, 0,
                   (64'd1 << 1) | (64'd1 << 5) | (64'd1 << 6) | (64'd1 << 11) | (64'd1 << 22));
        check_output("stray_done_cycle", done_cycle, 22);
        check_output("stray_done_count", done_count, 1);
        check_output("stray_av_count", av_count, 16);
        check_output("stray_addr_sum", addr_sum, 56);
        check_output("stray_busy_after", busy_after, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
